// File: rtl/mult_pkg.sv
// Shared types and constants for the iterative 32x32 shift-add multiplier.
// Build option: SIGNED_MULT_EN adds the FIX state used for signed (MULT) operation.
package mult_pkg;

  localparam int MULT_W = 32;
  localparam int PROD_W = 64;
  localparam int ITER   = 32;
  localparam int CNT_W  = $clog2(ITER) + 1;

`ifdef SIGNED_MULT_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd3
  } state_t;
`endif

endpackage

// File: rtl/add_opr.sv
// 32-bit ripple-carry adder used by the multiplier's accumulate step.
module add_opr (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] sum,
  output logic        co
);

  logic [32:0] carry;

  // Bit-serial carry chain, one full adder per bit.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = ci;
    for (int i = 0; i < 32; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    co = carry[32];
  end

endmodule

// File: rtl/mult_unit.sv
// Iterative shift-add multiplier: 32x32 -> 64, one partial product per cycle.
// Build option: define SIGNED_MULT_EN for signed (MULT) support via is_signed;
// operands are converted to magnitudes at load and the product is negated in FIX.
// Without it the unit performs unsigned multiplication (MULTU) only.
module mult_unit
  import mult_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
`ifdef SIGNED_MULT_EN
  input  logic        is_signed,
`endif
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_t              state;
  logic [MULT_W-1:0]   mcand;
  logic [PROD_W-1:0]   prod;
  logic [PROD_W-1:0]   prod_run;
  logic [CNT_W-1:0]    cnt;
  logic [MULT_W-1:0]   a_ld;
  logic [MULT_W-1:0]   b_ld;
  logic [MULT_W-1:0]   sum;
  logic                co;

`ifdef SIGNED_MULT_EN
  logic                neg;
  logic                neg_ld;

  function automatic logic [MULT_W-1:0] abs_val(input logic signed [MULT_W-1:0] x,
                                                input logic en);
    if (en && (x < 0)) return MULT_W'(-x);
    return x;
  endfunction

  function automatic logic [PROD_W-1:0] negate(input logic [PROD_W-1:0] x);
    return ~x + 64'd1;
  endfunction
`endif

  add_opr u_add (
    .a   (prod[63:32]),
    .b   (mcand),
    .ci  (1'b0),
    .sum (sum),
    .co  (co)
  );

  // Operand conditioning at load time (magnitudes and result sign in signed mode).
  always_comb begin
`ifdef SIGNED_MULT_EN
    a_ld   = abs_val(a, is_signed);
    b_ld   = abs_val(b, is_signed);
    neg_ld = is_signed & (a[31] ^ b[31]);
`else
    a_ld   = a;
    b_ld   = b;
`endif
  end

  // One shift-add step: adder carry-out becomes bit 63 ahead of the right shift.
  always_comb begin
    prod_run = {1'b0, prod[63:1]};
    if (prod[0]) prod_run = {co, sum, prod[31:1]};
  end

  // Control FSM and product register; outputs busy/done are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      prod  <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef SIGNED_MULT_EN
      neg   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            mcand <= a_ld;
            prod  <= {{MULT_W{1'b0}}, b_ld};
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
`ifdef SIGNED_MULT_EN
            neg   <= neg_ld;
`endif
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          prod <= prod_run;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(ITER - 1)) begin
`ifdef SIGNED_MULT_EN
            state <= ST_FIX;
`else
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
`endif
          end
        end
`ifdef SIGNED_MULT_EN
        ST_FIX: begin
          if (neg) prod <= negate(prod);
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
`endif
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign hi = prod[63:32];
  assign lo = prod[31:0];

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit (default unsigned build or SIGNED_MULT_EN).
module tb_mult_unit;

`ifdef SIGNED_MULT_EN
  localparam int LAT    = 34;
  localparam bit SGN_EN = 1'b1;
`else
  localparam int LAT    = 33;
  localparam bit SGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        is_signed;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mult_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
`ifdef SIGNED_MULT_EN
    .is_signed (is_signed),
`endif
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  // Reference product: exact 64-bit product of the (sign-extended) operands.
  function automatic logic [63:0] model_prod(input logic [31:0] x, input logic [31:0] y,
                                             input logic sgn);
    logic [63:0] xe;
    logic [63:0] ye;
    xe = sgn ? {{32{x[31]}}, x} : {32'h0, x};
    ye = sgn ? {{32{y[31]}}, y} : {32'h0, y};
    return xe * ye;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: when a start is accepted, when done is due, what hi/lo hold.
  int          cyc     = 0;
  int          due     = 0;
  bit          m_valid = 1'b0;
  bit          pending = 1'b0;
  bit          was_busy;
  logic [63:0] m_exp   = '0;
  logic [63:0] m_cur   = '0;

  initial begin
    forever begin
      @(posedge clk);
      was_busy = pending && (cyc < due);
      cyc++;
      if (rst) begin
        m_valid = 1'b1;
        pending = 1'b0;
        m_cur   = '0;
      end else if (m_valid) begin
        if (start && !was_busy) begin
          pending = 1'b1;
          due     = cyc + LAT - 1;
          m_exp   = model_prod(a, b, is_signed && SGN_EN);
        end
        if (pending && (cyc == due)) m_cur = m_exp;
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("busy", {63'h0, busy}, {63'h0, (pending && (cyc < due))});
        chk("done", {63'h0, done}, {63'h0, (pending && (cyc == due))});
        if (!(pending && (cyc < due))) chk("hilo", {hi, lo}, m_cur);
      end
    end
  end

  task automatic go(input logic [31:0] x, input logic [31:0] y, input logic s);
    @(negedge clk);
    a = x; b = y; is_signed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom; is_signed = 1'($urandom);
  endtask

  // Called one cycle after the start cycle; n counts cycles from the start cycle.
  task automatic wait_done(input int p1, input int p2, output int n);
    n = 1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (done === 1'b1) break;
      if (n == p1 || n == p2) begin
        start = 1'b1; a = $urandom; b = $urandom; is_signed = 1'($urandom);
      end
    end
  endtask

  task automatic op(input logic [31:0] x, input logic [31:0] y, input logic s,
                    input logic [63:0] want, input string nm);
    int n;
    go(x, y, s);
    wait_done(0, 0, n);
    chk({nm, "_lat"}, 64'(n), 64'(LAT));
    chk(nm, {hi, lo}, want);
  endtask

  initial begin
    int n;
    int pulses;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; is_signed = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {63'h0, busy}, 64'h0);
    chk("reset_done", {63'h0, done}, 64'h0);
    chk("reset_hilo", {hi, lo}, 64'h0);
    rst = 1'b0;

    chk("pin_3x5",   model_prod(32'd3, 32'd5, 1'b0), 64'h0000_0000_0000_000F);
    chk("pin_ones",  model_prod(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0), 64'hFFFF_FFFE_0000_0001);
    chk("pin_sneg",  model_prod(32'hFFFF_FFFE, 32'd3, 1'b1), 64'hFFFF_FFFF_FFFF_FFFA);
    chk("pin_smin",  model_prod(32'h8000_0000, 32'h8000_0000, 1'b1), 64'h4000_0000_0000_0000);

    op(32'd3,         32'd5,         1'b0, 64'h0000_0000_0000_000F, "u_3x5");
    op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "u_ones");
    op(32'd0,         32'hFFFF_FFFF, 1'b0, 64'h0,                   "u_zero");
    op(32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000, "u_min");
    op(32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000, "u_2p32");
    op(32'hFFFF_FFFF, 32'd2,         1'b0, 64'h0000_0001_FFFF_FFFE, "u_x2");
`ifdef SIGNED_MULT_EN
    op(32'hFFFF_FFFE, 32'd3,         1'b1, 64'hFFFF_FFFF_FFFF_FFFA, "s_m2x3");
    op(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "s_min");
    op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, "s_m1sq");
    op(32'h8000_0000, 32'd1,         1'b1, 64'hFFFF_FFFF_8000_0000, "s_minx1");
    op(32'd7,         32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, "s_7xm3");
`endif

    // Starts during RUN are ignored; a start in the DONE cycle restarts immediately.
    go(32'd1000, 32'd1000, 1'b0);
    wait_done(5, 20, n);
    chk("ign_lat", 64'(n), 64'(LAT));
    chk("ign_val", {hi, lo}, 64'd1000000);
    a = 32'd6; b = 32'd7; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    wait_done(0, 0, n);
    chk("restart_lat", 64'(n), 64'(LAT));
    chk("restart_val", {hi, lo}, 64'd42);

    // Reset in the middle of RUN aborts the multiply with no done pulse.
    go(32'd7, 32'd9, 1'b0);
    n = 1;
    while (n < 10) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", {63'h0, busy}, 64'h0);
    chk("mid_rst_hilo", {hi, lo}, 64'h0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    chk("mid_rst_nodone", 64'(pulses), 64'h0);

    // Random operands, checked by the per-cycle model comparison.
    for (int i = 0; i < 6; i++) begin
      go($urandom, $urandom, 1'($urandom));
      wait_done(0, 0, n);
      chk("rnd_lat", 64'(n), 64'(LAT));
    end
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_unit.md
MULT_UNIT -- requirements
Module: mult_unit

Interface
REQ-001 Parameter: none; width fixed at 32-bit operands, 64-bit product.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only when the block is ready.
REQ-005 a  input  32  multiplicand, sampled with an accepted start.
REQ-006 b  input  32  multiplier, sampled with an accepted start.
REQ-007 is_signed  input  1  two's-complement select, sampled with start; present only with SIGNED_MULT_EN.
REQ-008 busy  output  1  high while a multiply is in progress.
REQ-009 done  output  1  one-cycle pulse; hi/lo valid in that cycle.
REQ-010 hi  output  32  upper product word (MIPS HI).
REQ-011 lo  output  32  lower product word (MIPS LO).

Function
REQ-012 States: IDLE, RUN, FIX (SIGNED_MULT_EN only), DONE.
REQ-013 Start is accepted in IDLE or DONE; it is ignored in RUN and FIX.
REQ-014 Accepted start: load mcand=|a|, P={32'b0,|b|}, and iteration counter=0; then enter RUN.
REQ-015 Without SIGNED_MULT_EN, |x| means x.
REQ-016 RUN, per cycle: if P[0], sum=P[63:32]+mcand via 32-bit ripple adder, with carry-out co.
REQ-017 RUN update: P <= {co,sum,P[31:1]} when P[0]=1, else {1'b0,P[63:1]}.
REQ-018 RUN: counter increments each cycle; after the 32nd RUN cycle, go to FIX (macro) or DONE.
REQ-019 FIX: if the sign flag (a[31]^b[31] with is_signed) is set, P <= two's-complement negation of P; 1 cycle; then DONE.
REQ-020 DONE: done=1 for exactly 1 cycle; next state is RUN on a new accepted start, else IDLE.
REQ-021 Latency, start edge to done: 33 cycles without macro; 34 with macro.
REQ-022 hi=P[63:32] and lo=P[31:0] at all times; they hold the last product until the next accepted start.
REQ-023 busy=1 in RUN and FIX, 0 in IDLE and DONE.
REQ-024 Product is exact modulo 2^64 for all operand values, including 0, all-ones and 0x80000000.
REQ-025 Operand inputs may change freely after acceptance without affecting the result.

Reset
REQ-026 rst high at any clock edge, including mid-RUN or mid-FIX: state=IDLE, P=0, counter=0, busy=0, done=0, hi=lo=0.
REQ-027 rst takes priority over start in the same cycle; start is dropped.

Configuration
REQ-028 Macro SIGNED_MULT_EN defined: is_signed port, abs conversion at load, sign flag and FIX state present; MULT semantics.
REQ-029 SIGNED_MULT_EN undefined: unsigned only (MULTU); no is_signed port, no FIX state; latency 33.

Structure
REQ-030 Package mult_pkg: state enum type, MULT_W=32, PROD_W=64, ITER=32, counter width constant.
REQ-031 One sub-module: the existing 32-bit ripple adder add_opr, instantiated once with ci=0; its co is used as bit 63 before the shift.
REQ-032 FIX negation and abs conversion use separate combinational logic, not the shared adder.

Verification
REQ-033 Unsigned a=3, b=5 -> 33 cycles later done=1, hi=0x00000000, lo=0x0000000F.
REQ-034 Unsigned a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 (exercises adder carry-out).
REQ-035 Macro on, signed a=0xFFFFFFFE (-2), b=3 -> 34 cycles later hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-036 Macro on, signed a=b=0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-037 Start a=7, b=9; assert rst at RUN cycle 10 -> next cycle busy=0, hi=lo=0, and no done pulse follows.
REQ-038 Start pulses at RUN cycles 5 and 20 are ignored; restart in the DONE cycle -> done pulses exactly 33 (or 34) cycles apart.
